gonso_pixel_tx: RTL

Pixel scan-out transmitter for the gonso user project. It accepts rendered 8-bit grey pixels from the rasterizer through a valid/ready port and buffers them in a small FIFO. It emits them in raster order on the user I/O pixel bus: `color` on mprj_io[7:0] and a one-cycle `pixel_write` strobe on mprj_io[8]. The off-chip image capture samples this bus. Frame, line and underrun status go to the firmware-visible status logic.

---
 rtl/gonso_pixel_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/gonso_pixel_tx.sv
// Pixel scan-out transmitter: buffers rasterizer pixels in a small FIFO and
// strobes them out in raster order on the user I/O pixel bus.
module gonso_pixel_tx #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_color_i,
  output logic        in_ready_o,
  output logic [7:0]  color_o,
  output logic        pixel_write_o,
  output logic        line_end_o,
  output logic        frame_done_o,
  output logic        busy_o,
  output logic        underrun_o,
  output logic [12:0] pixel_count_o
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   OCC_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EMIT, S_GAP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [12:0]   pix_cnt_q, pix_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    color_q, color_d;
  logic          underrun_q, underrun_d;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          push, pop, fifo_full, fifo_empty;

  // Full/empty come from registered occupancy, so a pop never frees a slot
  // for a push in the same cycle.
  assign fifo_full  = (occ_q == OCC_FULL);
  assign fifo_empty = (occ_q == '0);
  assign push       = in_valid_i && !fifo_full;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    pix_cnt_d  = pix_cnt_q;
    gap_d      = gap_q;
    color_d    = color_q;
    underrun_d = underrun_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_FETCH;
          x_d        = '0;
          y_d        = '0;
          pix_cnt_d  = '0;
          underrun_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          color_d = fifo_mem[rd_ptr_q];
          state_d = S_EMIT;
        end else begin
          underrun_d = 1'b1;
        end
      end
      S_EMIT: begin
        pix_cnt_d = pix_cnt_q + 13'd1;
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
        if (x_q == X_LAST && y_q == Y_LAST) begin
          state_d = S_DONE;
        end else begin
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_FETCH;
        else gap_d = gap_q - GW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW + 1)'(1);
      2'b01:   occ_d = occ_q - (AW + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= in_color_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      pix_cnt_q  <= '0;
      gap_q      <= '0;
      color_q    <= '0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pix_cnt_q  <= pix_cnt_d;
      gap_q      <= gap_d;
      color_q    <= color_d;
      underrun_q <= underrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  assign in_ready_o    = !fifo_full;
  assign color_o       = color_q;
  assign pixel_write_o = (state_q == S_EMIT);
  assign line_end_o    = (state_q == S_EMIT) && (x_q == X_LAST);
  assign frame_done_o  = (state_q == S_DONE);
  assign busy_o        = (state_q != S_IDLE);
  assign underrun_o    = underrun_q;
  assign pixel_count_o = pix_cnt_q;

endmodule
